kgp_prog_loader: RTL and testbench

- Program loader for KGP-RISC: the writer side of instruction memory, whose words the fetch/control path later reads and decodes.
- Takes a byte stream (valid/ready), assembles big-endian 32-bit instruction words and checks each opcode field against the legal set (R, I, LS, BR1, BR2, BR3).
- Writes legal words to consecutive instruction-memory addresses from 0 and ends the session on a terminator word.
- Reports done, error code and word count to the host/testbench.

---
 rtl/kgp_prog_loader.sv | 119 +++++++++++
 tb/tb_kgp_prog_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kgp_prog_loader.sv
// KGP-RISC program loader: assembles a big-endian byte stream into 32-bit
// instruction words, screens opcodes and writes legal words to imem from 0.
module kgp_prog_loader #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DEPTH      = 1024,
  parameter logic [31:0] END_WORD   = 32'hFFFFFFFF,
  parameter logic [4:0]  MAX_OPCODE = 5'b00101
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERR
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [1:0]      ERR_NONE = 2'b00;
  localparam logic [1:0]      ERR_OPC  = 2'b01;
  localparam logic [1:0]      ERR_OVF  = 2'b10;

  state_t      state;
  logic [1:0]  bidx;
  // Only the first three bytes need storing; the fourth is used straight off the bus.
  logic [23:0] asm_q;
  logic [31:0] word;
  logic        accept;

  assign word   = {asm_q, in_data};
  assign accept = (state == S_RECV) && in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= ERR_NONE;
      word_count <= '0;
      bidx       <= '0;
      asm_q      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state      <= S_RECV;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= ERR_NONE;
            word_count <= '0;
            imem_addr  <= '0;
            bidx       <= '0;
          end
        end
        S_RECV: begin
          if (accept) begin
            case (bidx)
              2'd0: asm_q[23:16] <= in_data;
              2'd1: asm_q[15:8]  <= in_data;
              2'd2: asm_q[7:0]   <= in_data;
              default: ;
            endcase
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              in_ready <= 1'b0;
              if (word == END_WORD) begin
                state <= S_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else if (word[31:27] > MAX_OPCODE) begin
                state <= S_ERR;
                err   <= ERR_OPC;
                busy  <= 1'b0;
              end else if (word_count == DEPTH_C) begin
                state <= S_ERR;
                err   <= ERR_OVF;
                busy  <= 1'b0;
              end else begin
                state      <= S_WRITE;
                imem_we    <= 1'b1;
                imem_wdata <= word;
                imem_addr  <= word_count[ADDR_W-1:0];
              end
            end
          end
        end
        S_WRITE: begin
          state      <= S_RECV;
          imem_we    <= 1'b0;
          in_ready   <= 1'b1;
          word_count <= word_count + 1'b1;
          bidx       <= '0;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          imem_we  <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kgp_prog_loader.sv
// Bench for kgp_prog_loader: byte-level reference model compared every cycle,
// plus literal checks on memory contents and session results.
module tb_kgp_prog_loader;
  localparam int AW = 4;
  localparam int DP = 4;
  localparam logic [31:0] ENDW = 32'hFFFFFFFF;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, imem_we, busy, done;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [1:0]    err;
  logic [AW:0]   word_count;

  kgp_prog_loader #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: session phase plus a queue of bytes of the word in flight.
  localparam int P_IDLE = 0, P_RECV = 1, P_WRITE = 2, P_END = 3;
  int          m_phase;
  logic [7:0]  m_q[$];
  logic        m_ready, m_we, m_busy, m_done;
  logic [1:0]  m_err;
  logic [AW-1:0] m_addr;
  logic [31:0] m_wdata, m_w;
  int          m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = P_IDLE; m_q.delete();
      m_ready = 0; m_we = 0; m_busy = 0; m_done = 0; m_err = 0;
      m_addr = 0; m_wdata = 0; m_cnt = 0;
    end else if (m_phase == P_IDLE || m_phase == P_END) begin
      if (start) begin
        m_phase = P_RECV; m_q.delete();
        m_ready = 1; m_busy = 1; m_done = 0; m_err = 0; m_cnt = 0; m_addr = 0;
      end
    end else if (m_phase == P_WRITE) begin
      m_we = 0; m_cnt = m_cnt + 1; m_ready = 1; m_phase = P_RECV;
    end else if (in_valid && m_ready) begin
      m_q.push_back(in_data);
      if (m_q.size() == 4) begin
        m_w = {m_q[0], m_q[1], m_q[2], m_q[3]};
        m_q.delete();
        m_ready = 0;
        if (m_w == ENDW) begin
          m_phase = P_END; m_done = 1; m_busy = 0;
        end else if (m_w[31:27] > 5) begin
          m_phase = P_END; m_err = 2'b01; m_busy = 0;
        end else if (m_cnt == DP) begin
          m_phase = P_END; m_err = 2'b10; m_busy = 0;
        end else begin
          m_phase = P_WRITE; m_we = 1; m_wdata = m_w; m_addr = AW'(m_cnt);
        end
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(m_ready));
    check("imem_we", 32'(imem_we), 32'(m_we));
    check("imem_addr", 32'(imem_addr), 32'(m_addr));
    check("imem_wdata", imem_wdata, m_wdata);
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("err", 32'(err), 32'(m_err));
    check("word_count", 32'(word_count), 32'(m_cnt));
  end

  logic [31:0] mem [16];
  int wr_total = 0;
  always @(posedge clk) begin
    if (!rst && imem_we) begin
      mem[imem_addr] = imem_wdata;
      wr_total++;
    end
  end

  // All tasks start and end at a falling edge.
  task automatic send_byte(logic [7:0] b);
    int t;
    if ($urandom_range(0, 2) == 0) begin
      in_valid = 0; in_data = 8'($urandom);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    in_valid = 1; in_data = b; t = 0;
    while (!in_ready && t < 40) begin @(negedge clk); t++; end
    if (t == 40) begin
      tests++; fails++;
      $display("FAIL handshake_timeout: got no in_ready, required in_ready within 40 cycles");
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 0;
  endtask

  task automatic send_word(logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
  endtask

  task automatic pulse_start();
    start = 1; @(negedge clk); start = 0;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic present_ignored(int n);
    in_valid = 1;
    repeat (n) begin in_data = 8'($urandom); @(negedge clk); end
    in_valid = 0;
  endtask

  function automatic logic [31:0] legal_word();
    return {5'($urandom_range(0, 5)), 27'($urandom)};
  endfunction

  int wr0;
  logic [31:0] lst[$];
  logic [31:0] w;
  bit ovf;
  int n;

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_word_count", 32'(word_count), 0);

    // Basic session: two words then terminator.
    pulse_start(); wr0 = wr_total;
    send_word(32'h00000001); send_word(32'h08400000); send_word(ENDW);
    settle();
    check("s1_mem0", mem[0], 32'h00000001);
    check("s1_mem1", mem[1], 32'h08400000);
    check("s1_done", 32'(done), 1);
    check("s1_err", 32'(err), 0);
    check("s1_count", 32'(word_count), 2);
    check("s1_writes", 32'(wr_total - wr0), 2);
    present_ignored(3);

    // Illegal opcode after one legal word.
    pulse_start(); wr0 = wr_total;
    send_word(32'h00000ABC); send_word(32'h30000000);
    settle();
    check("s2_err", 32'(err), 1);
    check("s2_count", 32'(word_count), 1);
    check("s2_writes", 32'(wr_total - wr0), 1);
    check("s2_mem0", mem[0], 32'h00000ABC);
    check("s2_in_ready", 32'(in_ready), 0);
    present_ignored(3);

    // Start in ERR clears err; overflow on fifth word; ignored start mid-session.
    pulse_start(); wr0 = wr_total;
    check("s3_err_cleared", 32'(err), 0);
    for (int i = 0; i < 5; i++) begin
      send_word(32'h10000000 + 32'(i));
      if (i == 1) pulse_start();
    end
    settle();
    check("s3_err", 32'(err), 2);
    check("s3_count", 32'(word_count), 4);
    check("s3_writes", 32'(wr_total - wr0), 4);
    for (int i = 0; i < 4; i++) check("s3_mem", mem[i], 32'h10000000 + 32'(i));

    // Exactly DEPTH words then terminator.
    pulse_start(); wr0 = wr_total;
    for (int i = 0; i < 4; i++) send_word(32'h28000000 + 32'(i));
    send_word(ENDW);
    settle();
    check("s4_done", 32'(done), 1);
    check("s4_err", 32'(err), 0);
    check("s4_count", 32'(word_count), 4);
    check("s4_writes", 32'(wr_total - wr0), 4);

    // Async reset after two bytes of word 3.
    pulse_start();
    send_word(32'h01234567); send_word(32'h02345678);
    send_byte(8'h03); send_byte(8'h11);
    #2 rst = 1;
    #1;
    check("ar_in_ready", 32'(in_ready), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_we", 32'(imem_we), 0);
    check("ar_addr", 32'(imem_addr), 0);
    check("ar_wdata", imem_wdata, 0);
    check("ar_count", 32'(word_count), 0);
    @(negedge clk); rst = 0; @(negedge clk);
    pulse_start(); wr0 = wr_total;
    send_word(32'h20ABCDEF); send_word(ENDW);
    settle();
    check("ar_mem0", mem[0], 32'h20ABCDEF);
    check("ar_count2", 32'(word_count), 1);
    check("ar_done", 32'(done), 1);

    // Randomized sessions.
    for (int r = 0; r < 25; r++) begin
      pulse_start(); wr0 = wr_total; lst.delete(); ovf = 0;
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) begin
        w = legal_word(); send_word(w);
        if (i == DP) begin ovf = 1; break; end
        lst.push_back(w);
      end
      if (!ovf) begin
        if ($urandom_range(0, 2) == 0) send_word({5'($urandom_range(6, 30)), 27'($urandom)});
        else send_word(ENDW);
      end
      settle();
      check("rnd_writes", 32'(wr_total - wr0), 32'(lst.size()));
      check("rnd_count", 32'(word_count), 32'(lst.size()));
      if (ovf) check("rnd_ovf_err", 32'(err), 2);
      for (int j = 0; j < lst.size(); j++) check("rnd_mem", mem[j], lst[j]);
      if ($urandom_range(0, 1) == 1) present_ignored(2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
